// File: rtl/cr16_control.sv
// Multi-cycle fetch/decode/execute/writeback controller feeding a registered cr16 ALU.
// Holds the 16-entry register file and the processor status register.
module cr16_control #(
    parameter int                    WIDTH      = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [15:0]           mem_data,
    output logic                  alu_enable,
    output logic [3:0]            alu_opcode,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    input  logic [WIDTH-1:0]      alu_c,
    input  logic [4:0]            alu_status,
    output logic [4:0]            psr,
    output logic                  retire,
    output logic                  illegal
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [15:0]           ir;
    logic [WIDTH-1:0]      regs [16];

    logic [3:0]       ir_class, ir_rdest, ir_ext, ir_rsrc;
    logic             dec_legal;
    logic [3:0]       dec_opcode;
    logic [WIDTH-1:0] dec_a;
    logic [WIDTH-1:0] imm_sext, imm_zext, imm_shift;

    assign ir_class  = ir[15:12];
    assign ir_rdest  = ir[11:8];
    assign ir_ext    = ir[7:4];
    assign ir_rsrc   = ir[3:0];
    assign imm_sext  = {{(WIDTH-8){ir[7]}}, ir[7:0]};
    assign imm_zext  = {{(WIDTH-8){1'b0}}, ir[7:0]};
    assign imm_shift = {{(WIDTH-4){1'b0}}, ir[3:0]};

    assign mem_addr = pc;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        dec_legal  = 1'b1;
        dec_opcode = ir_ext;
        dec_a      = regs[ir_rsrc];
        unique case (ir_class)
            4'h0: dec_legal = (ir_ext != 4'hF);
            4'h5: begin dec_opcode = 4'd0;  dec_a = imm_sext;  end
            4'h9: begin dec_opcode = 4'd4;  dec_a = imm_sext;  end
            4'hB: begin dec_opcode = 4'd5;  dec_a = imm_sext;  end
            4'h1: begin dec_opcode = 4'd7;  dec_a = imm_zext;  end
            4'h2: begin dec_opcode = 4'd8;  dec_a = imm_zext;  end
            4'h3: begin dec_opcode = 4'd9;  dec_a = imm_zext;  end
            4'h8: begin dec_opcode = 4'd11; dec_a = imm_shift; end
            default: dec_legal = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH:     if (mem_ack) state_next = S_DECODE;
            S_DECODE:    state_next = dec_legal ? S_EXECUTE : S_FETCH;
            S_EXECUTE:   state_next = S_WRITEBACK;
            S_WRITEBACK: state_next = S_FETCH;
            default:     state_next = S_FETCH;
        endcase
    end

    // Reset is folded into mem_req so an aborted fetch request drops immediately.
    always_comb begin
        mem_req    = rst_n && (state == S_FETCH);
        alu_enable = (state == S_EXECUTE);
        retire     = (state == S_WRITEBACK);
    end

    // NOTE: the register file is cleared by reset, so it is built from flops, not a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            ir         <= '0;
            psr        <= '0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            illegal    <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            illegal <= 1'b0;
            unique case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir <= mem_data;
                        pc <= pc + ADDR_WIDTH'(1);
                    end
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        alu_opcode <= dec_opcode;
                        alu_a      <= dec_a;
                        alu_b      <= regs[ir_rdest];
                    end else begin
                        illegal <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    // Compares (CMP, CMPU, CMPI) only update the status register.
                    if (alu_opcode != 4'd5 && alu_opcode != 4'd6) regs[ir_rdest] <= alu_c;
                    psr <= alu_status;
                end
                default: ;
            endcase
        end
    end

endmodule
